mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request address width.
REQ-002 SHALL have parameter DATA_W, default 128, memory line width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-low reset (0 = reset, sampled at clk rising edge).
REQ-005 SHALL have icache request ports:
- ic_req_valid, input, 1
- ic_req_ready, output, 1
- ic_req_addr, input, ADDR_W
REQ-006 SHALL have icache response ports ic_resp_valid, output, 1.
REQ-007 SHALL have dcache request ports:
- dc_req_valid, input, 1
- dc_req_ready, output, 1
- dc_req_rw, input, 1 (1 = write)
- dc_req_addr, input, ADDR_W
- dc_req_data, input, DATA_W
REQ-008 SHALL have dcache response ports dc_resp_valid, output, 1.
REQ-009 SHALL have memory request ports:
- mem_req_valid, output, 1
- mem_req_ready, input, 1
- mem_req_rw, output, 1
- mem_req_addr, output, ADDR_W
- mem_req_data, output, DATA_W
REQ-010 SHALL have memory response ports:
- mem_resp_valid, input, 1
- mem_resp_data, input, DATA_W
REQ-011 SHALL have port resp_data, output, DATA_W, shared read data to both caches, equal to mem_resp_data.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT_RESP, with at most one memory transaction outstanding.
REQ-013 SHALL behave as follows in IDLE:
- if exactly one xx_req_valid is high, grant it: xx_req_ready=1 combinationally in that cycle.
- if neither is valid, both readys are 0.
REQ-014 SHALL, when both requests are valid in IDLE, grant the requester not granted last (round-robin bit last_grant); last_grant resets to icache, so dcache wins the first tie.
REQ-015 SHALL, on grant, perform all of the following:
- latch addr, rw (icache grant forces rw=0) and data into internal registers.
- record owner.
- update last_grant.
- transition to REQ.
REQ-016 SHALL drive mem_req_valid=1 only in REQ, with mem_req_addr/rw/data taken from the latched registers, stable until accepted.
REQ-017 SHALL, in REQ with mem_req_ready=1:
- transition to WAIT_RESP if the latched rw is 0.
- transition to IDLE if the latched rw is 1; writes produce no response and dc_resp_valid is never asserted for them.
REQ-018 SHALL, in WAIT_RESP with mem_resp_valid=1:
- assert the owner's xx_resp_valid in the same cycle (combinational).
- transition to IDLE on the next edge.
REQ-019 SHALL ignore mem_resp_valid outside WAIT_RESP: no resp_valid and no state change.
REQ-020 SHALL hold both xx_req_ready at 0 in REQ and WAIT_RESP.
REQ-021 SHALL produce the following minimum latencies:
- grant in cycle N gives mem_req_valid from cycle N+1.
- a read response in cycle M permits the next grant in cycle M+1.
REQ-022 SHALL ignore requests whose xx_req_valid drops before grant; no queuing occurs inside the block.
REQ-023 SHALL be fixed at DATA_W and ADDR_W; no width conversion and no address arithmetic.

Reset
REQ-024 SHALL, while reset=0 at a clock edge, set:
- state=IDLE.
- last_grant=icache.
- owner=icache.
- latched addr/data/rw=0.
REQ-025 SHALL have these output values during and after reset until the next grant:
- mem_req_valid=0.
- ic_req_ready=0 and dc_req_ready=0 while reset=0.
- ic_resp_valid=0 and dc_resp_valid=0.
REQ-026 SHALL, on reset asserted mid-transaction (REQ or WAIT_RESP), abandon the transaction and return to IDLE; a late mem_resp_valid is then ignored per REQ-019.

Verification
REQ-027 SHALL cover: icache-only read at addr 0x0000_1000, mem_req_ready=1 immediately, response after 3 cycles with data 0xDEADBEEF... -> ic_req_ready high 1 cycle, mem_req_valid in the following cycle with rw=0 addr 0x1000, ic_resp_valid=1 in the response cycle, dc_resp_valid=0 throughout.
REQ-028 SHALL cover: both valid after reset, with dc addr 0x2000 read and ic addr 0x3000 -> dcache granted first; after the dc response, ic is granted the next cycle; the third tie goes to dcache.
REQ-029 SHALL cover: dcache write to addr 0x4000 with data 0x1234, mem_req_ready held low 5 cycles -> mem_req_valid/addr/data stable for 6 cycles, IDLE after acceptance, no dc_resp_valid.
REQ-030 SHALL cover: reset=0 pulsed during WAIT_RESP, then mem_resp_valid=1 one cycle later -> no resp_valid, state IDLE, next ic request granted normally.
REQ-031 SHALL cover: spurious mem_resp_valid=1 in IDLE with no requests -> all outputs 0, state unchanged.
REQ-032 SHALL cover: ic_req_valid deasserted in the same cycle dc_req_valid rises while in REQ -> after return to IDLE only dcache is granted; no icache transaction appears at the memory port.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter between an icache and a dcache sharing one
//            memory port, with at most one memory transaction in flight.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,          // synchronous, active-low

  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,

  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [DATA_W-1:0] dc_req_data,
  output logic              dc_resp_valid,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,

  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,

  output logic [DATA_W-1:0] resp_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  // Requester encoding used for owner_q / last_grant_q
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  state_t              state_q;
  logic                last_grant_q;
  logic                owner_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;

  logic                in_idle;
  logic                grant_ic;
  logic                grant_dc;
  logic                resp_hit;

  // Grant decision: a lone requester wins; on a tie the side not served last wins
  always_comb begin
    in_idle  = (state_q == IDLE);
    grant_dc = dc_req_valid && (!ic_req_valid || (last_grant_q == OWN_IC));
    grant_ic = ic_req_valid && (!dc_req_valid || (last_grant_q == OWN_DC));
    resp_hit = (state_q == WAIT_RESP) && mem_resp_valid;
  end

  // Handshake outputs; everything is held low while reset is asserted
  always_comb begin
    ic_req_ready  = reset && in_idle && grant_ic;
    dc_req_ready  = reset && in_idle && grant_dc;
    ic_resp_valid = reset && resp_hit && (owner_q == OWN_IC);
    dc_resp_valid = reset && resp_hit && (owner_q == OWN_DC);
    mem_req_valid = reset && (state_q == REQ);
    mem_req_rw    = rw_q;
    mem_req_addr  = addr_q;
    mem_req_data  = data_q;
    resp_data     = mem_resp_data;
  end

  // Transaction FSM: latch on grant, present in REQ, await read data in WAIT_RESP
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_IC;
      owner_q      <= OWN_IC;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_dc) begin
            state_q      <= REQ;
            owner_q      <= OWN_DC;
            last_grant_q <= OWN_DC;
            rw_q         <= dc_req_rw;
            addr_q       <= dc_req_addr;
            data_q       <= dc_req_data;
          end else if (grant_ic) begin
            // icache only reads, so rw is forced low and no write data exists
            state_q      <= REQ;
            owner_q      <= OWN_IC;
            last_grant_q <= OWN_IC;
            rw_q         <= 1'b0;
            addr_q       <= ic_req_addr;
            data_q       <= '0;
          end
        end
        REQ: begin
          // Writes complete on acceptance; reads wait for returned data
          if (mem_req_ready) begin
            state_q <= rw_q ? IDLE : WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem_resp_valid) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter: directed scenarios plus a
//            randomized run compared against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  logic              clk;
  logic              reset;
  logic              ic_req_valid;
  logic              ic_req_ready;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_resp_valid;
  logic              dc_req_valid;
  logic              dc_req_ready;
  logic              dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [DATA_W-1:0] dc_req_data;
  logic              dc_resp_valid;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic [DATA_W-1:0] resp_data;

  int total;
  int bad;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .ic_req_valid  (ic_req_valid),
    .ic_req_ready  (ic_req_ready),
    .ic_req_addr   (ic_req_addr),
    .ic_resp_valid (ic_resp_valid),
    .dc_req_valid  (dc_req_valid),
    .dc_req_ready  (dc_req_ready),
    .dc_req_rw     (dc_req_rw),
    .dc_req_addr   (dc_req_addr),
    .dc_req_data   (dc_req_data),
    .dc_resp_valid (dc_resp_valid),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_rw    (mem_req_rw),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .resp_data     (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_req_valid   = 1'b0;
    ic_req_addr    = '0;
    dc_req_valid   = 1'b0;
    dc_req_rw      = 1'b0;
    dc_req_addr    = '0;
    dc_req_data    = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    reset          = 1'b0;
    ic_req_valid   = 1'b1;
    dc_req_valid   = 1'b1;
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (ic_req_ready !== 1'b0) begin bad++; $display("FAIL reset_ic_ready: got %b want 0", ic_req_ready); end
      total++; if (dc_req_ready !== 1'b0) begin bad++; $display("FAIL reset_dc_ready: got %b want 0", dc_req_ready); end
      total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid: got %b want 0", mem_req_valid); end
      total++; if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin bad++; $display("FAIL reset_resp: got %b want 00", {ic_resp_valid, dc_resp_valid}); end
    end
    clear_inputs();
    reset = 1'b1;
    #1;
    total++; if ({ic_req_ready, dc_req_ready, mem_req_valid, ic_resp_valid, dc_resp_valid} !== 5'b0)
      begin bad++; $display("FAIL reset_release_outputs: got %b want 00000", {ic_req_ready, dc_req_ready, mem_req_valid, ic_resp_valid, dc_resp_valid}); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ic_read();
    clear_inputs();
    ic_req_valid  = 1'b1;
    ic_req_addr   = 32'h0000_1000;
    mem_req_ready = 1'b1;
    #1;
    total++; if (ic_req_ready !== 1'b1) begin bad++; $display("FAIL ic_read_grant: got %b want 1", ic_req_ready); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL ic_read_no_early_mem: got %b want 0", mem_req_valid); end
    tick();
    ic_req_valid = 1'b0;
    #1;
    total++; if (mem_req_valid !== 1'b1 || mem_req_rw !== 1'b0 || mem_req_addr !== 32'h0000_1000)
      begin bad++; $display("FAIL ic_read_mem_req: got v=%b rw=%b a=%h want v=1 rw=0 a=00001000", mem_req_valid, mem_req_rw, mem_req_addr); end
    total++; if (ic_req_ready !== 1'b0) begin bad++; $display("FAIL ic_read_ready_one_cycle: got %b want 0", ic_req_ready); end
    tick();
    for (int i = 0; i < 2; i++) begin
      total++; if ({ic_resp_valid, dc_resp_valid, mem_req_valid} !== 3'b000)
        begin bad++; $display("FAIL ic_read_wait: got %b want 000", {ic_resp_valid, dc_resp_valid, mem_req_valid}); end
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = {4{32'hDEAD_BEEF}};
    #1;
    total++; if (ic_resp_valid !== 1'b1 || dc_resp_valid !== 1'b0)
      begin bad++; $display("FAIL ic_read_resp: got ic=%b dc=%b want ic=1 dc=0", ic_resp_valid, dc_resp_valid); end
    total++; if (resp_data !== {4{32'hDEAD_BEEF}}) begin bad++; $display("FAIL ic_read_data: got %h want %h", resp_data, {4{32'hDEAD_BEEF}}); end
    tick();
    clear_inputs();
    #1;
    total++; if ({ic_resp_valid, dc_resp_valid, mem_req_valid} !== 3'b000)
      begin bad++; $display("FAIL ic_read_done: got %b want 000", {ic_resp_valid, dc_resp_valid, mem_req_valid}); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [ADDR_W-1:0] exp_addr [3];
    logic              exp_dc   [3];
    exp_addr[0] = 32'h2000; exp_dc[0] = 1'b1;
    exp_addr[1] = 32'h3000; exp_dc[1] = 1'b0;
    exp_addr[2] = 32'h2000; exp_dc[2] = 1'b1;
    clear_inputs();
    do_reset();
    mem_req_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      // Both request on every round; the response cycle is followed directly by the next grant
      ic_req_valid = 1'b1; ic_req_addr = 32'h3000;
      dc_req_valid = 1'b1; dc_req_addr = 32'h2000; dc_req_rw = 1'b0;
      mem_resp_valid = 1'b0;
      #1;
      total++; if ({dc_req_ready, ic_req_ready} !== {exp_dc[n], ~exp_dc[n]})
        begin bad++; $display("FAIL rr_grant_%0d: got dc=%b ic=%b want dc=%b", n, dc_req_ready, ic_req_ready, exp_dc[n]); end
      tick();
      #1;
      total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr[n] || mem_req_rw !== 1'b0)
        begin bad++; $display("FAIL rr_mem_req_%0d: got v=%b a=%h want v=1 a=%h", n, mem_req_valid, mem_req_addr, exp_addr[n]); end
      tick();
      mem_resp_valid = 1'b1;
      mem_resp_data  = {DATA_W{1'b0}} | n;
      #1;
      total++; if ({dc_resp_valid, ic_resp_valid} !== {exp_dc[n], ~exp_dc[n]})
        begin bad++; $display("FAIL rr_resp_%0d: got dc=%b ic=%b want dc=%b", n, dc_resp_valid, ic_resp_valid, exp_dc[n]); end
      tick();
    end
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_write_stall();
    clear_inputs();
    dc_req_valid = 1'b1; dc_req_rw = 1'b1;
    dc_req_addr  = 32'h4000; dc_req_data = 128'h1234;
    #1;
    total++; if (dc_req_ready !== 1'b1) begin bad++; $display("FAIL wr_grant: got %b want 1", dc_req_ready); end
    tick();
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      mem_req_ready = (i == 5);
      #1;
      total++; if (mem_req_valid !== 1'b1 || mem_req_rw !== 1'b1 || mem_req_addr !== 32'h4000 || mem_req_data !== 128'h1234)
        begin bad++; $display("FAIL wr_stable_%0d: got v=%b rw=%b a=%h d=%h", i, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data); end
      total++; if ({dc_req_ready, ic_req_ready, dc_resp_valid} !== 3'b000)
        begin bad++; $display("FAIL wr_quiet_%0d: got %b want 000", i, {dc_req_ready, ic_req_ready, dc_resp_valid}); end
      tick();
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    total++; if ({mem_req_valid, dc_resp_valid, ic_resp_valid} !== 3'b000)
      begin bad++; $display("FAIL wr_no_resp: got %b want 000", {mem_req_valid, dc_resp_valid, ic_resp_valid}); end
    // Probe: an immediate request must be granted, proving the block is back in IDLE
    ic_req_valid = 1'b1;
    #1;
    total++; if (ic_req_ready !== 1'b1) begin bad++; $display("FAIL wr_back_idle: got %b want 1", ic_req_ready); end
    clear_inputs();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    clear_inputs();
    ic_req_valid = 1'b1; ic_req_addr = 32'h5000; mem_req_ready = 1'b1;
    tick();
    ic_req_valid = 1'b0;
    tick();                       // now waiting for read data
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mem_resp_valid = 1'b1;
    #1;
    total++; if ({ic_resp_valid, dc_resp_valid, mem_req_valid} !== 3'b000)
      begin bad++; $display("FAIL rstmid_late_resp: got %b want 000", {ic_resp_valid, dc_resp_valid, mem_req_valid}); end
    tick();
    mem_resp_valid = 1'b0;
    ic_req_valid = 1'b1; ic_req_addr = 32'h6000;
    #1;
    total++; if (ic_req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_regrant: got %b want 1", ic_req_ready); end
    tick();
    ic_req_valid = 1'b0;
    #1;
    total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h6000)
      begin bad++; $display("FAIL rstmid_mem_req: got v=%b a=%h want v=1 a=00006000", mem_req_valid, mem_req_addr); end
    tick();
    mem_resp_valid = 1'b1;
    #1;
    total++; if (ic_resp_valid !== 1'b1) begin bad++; $display("FAIL rstmid_resp: got %b want 1", ic_resp_valid); end
    tick();
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_spurious();
    clear_inputs();
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({ic_req_ready, dc_req_ready, mem_req_valid, ic_resp_valid, dc_resp_valid} !== 5'b0)
        begin bad++; $display("FAIL spurious_%0d: got %b want 00000", i, {ic_req_ready, dc_req_ready, mem_req_valid, ic_resp_valid, dc_resp_valid}); end
      tick();
    end
    dc_req_valid = 1'b1;
    #1;
    total++; if (dc_req_ready !== 1'b1) begin bad++; $display("FAIL spurious_still_idle: got %b want 1", dc_req_ready); end
    clear_inputs();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_drop();
    clear_inputs();
    ic_req_valid = 1'b1; ic_req_addr = 32'h7000;
    tick();                       // icache granted, memory stalls
    tick();
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 32'h8000;
    #1;
    total++; if ({ic_req_ready, dc_req_ready} !== 2'b00)
      begin bad++; $display("FAIL drop_busy_ready: got %b want 00", {ic_req_ready, dc_req_ready}); end
    total++; if (mem_req_addr !== 32'h7000) begin bad++; $display("FAIL drop_first_addr: got %h want 00007000", mem_req_addr); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    total++; if ({dc_req_ready, ic_req_ready} !== 2'b10)
      begin bad++; $display("FAIL drop_dc_only: got dc=%b ic=%b want dc=1 ic=0", dc_req_ready, ic_req_ready); end
    tick();
    dc_req_valid = 1'b0;
    #1;
    total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000)
      begin bad++; $display("FAIL drop_next_txn: got v=%b a=%h want v=1 a=00008000", mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    total++; if ({dc_resp_valid, ic_resp_valid} !== 2'b10)
      begin bad++; $display("FAIL drop_dc_resp: got dc=%b ic=%b want dc=1 ic=0", dc_resp_valid, ic_resp_valid); end
    tick();
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference: the in-flight transaction is a queue entry;
  // an empty queue means the arbiter can accept a new request.
  typedef struct {
    bit                is_dc;
    bit                rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                sent;
  } txn_t;

  task automatic test_random();
    txn_t q[$];
    txn_t t;
    bit   last_dc;
    bit   idle, win_ic, win_dc;
    bit   e_icr, e_dcr, e_mv, e_icv, e_dcv;
    clear_inputs();
    do_reset();
    last_dc = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset          = ($urandom_range(0, 59) != 0);
      ic_req_valid   = $urandom_range(0, 1) == 1;
      ic_req_addr    = $urandom;
      dc_req_valid   = $urandom_range(0, 1) == 1;
      dc_req_rw      = $urandom_range(0, 1) == 1;
      dc_req_addr    = $urandom;
      dc_req_data    = {$urandom, $urandom, $urandom, $urandom};
      mem_req_ready  = $urandom_range(0, 2) != 0;
      mem_resp_valid = $urandom_range(0, 2) == 0;
      mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      idle   = (q.size() == 0);
      win_dc = dc_req_valid && (!ic_req_valid || !last_dc);
      win_ic = ic_req_valid && (!dc_req_valid || last_dc);
      e_icr  = reset && idle && win_ic;
      e_dcr  = reset && idle && win_dc;
      e_mv   = reset && !idle && !q[0].sent;
      e_icv  = reset && !idle && q[0].sent && mem_resp_valid && !q[0].is_dc;
      e_dcv  = reset && !idle && q[0].sent && mem_resp_valid && q[0].is_dc;
      total++; if ({ic_req_ready, dc_req_ready} !== {e_icr, e_dcr})
        begin bad++; $display("FAIL rnd_ready c%0d: got ic=%b dc=%b want ic=%b dc=%b", cyc, ic_req_ready, dc_req_ready, e_icr, e_dcr); end
      total++; if (mem_req_valid !== e_mv)
        begin bad++; $display("FAIL rnd_mem_valid c%0d: got %b want %b", cyc, mem_req_valid, e_mv); end
      if (e_mv) begin
        total++; if (mem_req_rw !== q[0].rw || mem_req_addr !== q[0].addr || (q[0].rw && mem_req_data !== q[0].data))
          begin bad++; $display("FAIL rnd_mem_fields c%0d: got rw=%b a=%h d=%h want rw=%b a=%h d=%h", cyc, mem_req_rw, mem_req_addr, mem_req_data, q[0].rw, q[0].addr, q[0].data); end
      end
      total++; if ({ic_resp_valid, dc_resp_valid} !== {e_icv, e_dcv})
        begin bad++; $display("FAIL rnd_resp c%0d: got ic=%b dc=%b want ic=%b dc=%b", cyc, ic_resp_valid, dc_resp_valid, e_icv, e_dcv); end
      total++; if (resp_data !== mem_resp_data)
        begin bad++; $display("FAIL rnd_resp_data c%0d: got %h want %h", cyc, resp_data, mem_resp_data); end
      // Advance the model across the clock edge
      if (!reset) begin
        q.delete();
        last_dc = 1'b0;
      end else if (idle) begin
        if (win_dc) begin
          t.is_dc = 1'b1; t.rw = dc_req_rw; t.addr = dc_req_addr; t.data = dc_req_data; t.sent = 1'b0;
          q.push_back(t);
          last_dc = 1'b1;
        end else if (win_ic) begin
          t.is_dc = 1'b0; t.rw = 1'b0; t.addr = ic_req_addr; t.data = '0; t.sent = 1'b0;
          q.push_back(t);
          last_dc = 1'b0;
        end
      end else if (!q[0].sent) begin
        if (mem_req_ready) begin
          if (q[0].rw) void'(q.pop_front());
          else q[0].sent = 1'b1;
        end
      end else if (mem_resp_valid) begin
        void'(q.pop_front());
      end
      tick();
    end
    clear_inputs();
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_ic_read();
    test_round_robin();
    test_write_stall();
    test_reset_mid();
    test_spurious();
    test_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
